// File: rtl/ind_led_bank_if.sv
// Peripheral bus between the CPU side and the LED bank: strobes, address,
// write data and registered read data.
interface ind_led_bank_if;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] d_in;
    logic [7:0] d_out;

    modport master (
        output cs,
        output rd,
        output wr,
        output addr,
        output d_in,
        input  d_out
    );

    modport slave (
        input  cs,
        input  rd,
        input  wr,
        input  addr,
        input  d_in,
        output d_out
    );
endinterface

// File: rtl/ind_led_bank.sv
// Bank of N_LED bus-programmable indicator channels (off/on/blink/counted burst)
// sharing one blink prescaler, with global enable, output inversion and readback.
module ind_led_bank #(
    parameter int unsigned N_LED     = 2,
    parameter int unsigned BLINK_DIV = 25000000,
    parameter int unsigned DIV_W     = 25
) (
    input  logic             clk,
    input  logic             rst,
    ind_led_bank_if.slave    bus,
    output logic [N_LED-1:0] led
);
    localparam logic [3:0]       ADDR_GLOBAL = 4'h8;
    localparam logic [3:0]       ADDR_ID     = 4'hF;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(BLINK_DIV - 1);

    logic [N_LED-1:0][1:0] mode_q, mode_d;
    logic [N_LED-1:0][3:0] cnt_q, cnt_d;
    logic [N_LED-1:0]      phase_q, phase_d;
    logic [N_LED-1:0]      led_q, led_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  en_q, en_d;
    logic                  inv_q, inv_d;
    logic                  wr_q;
    logic [7:0]            d_out_q, d_out_d;

    logic       wr_act, commit, rd_act, tick;
    logic [7:0] rdata;
    logic       unused_d_in;

    assign unused_d_in = ^bus.d_in[7:6];

    always_comb begin
        wr_act = bus.cs & bus.wr;
        commit = wr_act & ~wr_q;
        rd_act = bus.cs & bus.rd & ~bus.wr;
        tick   = en_q && (div_q == DIV_LAST);

        div_d   = div_q;
        en_d    = en_q;
        inv_d   = inv_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        led_d   = '0;
        rdata   = 8'h00;

        if (en_q) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        for (int i = 0; i < N_LED; i++) begin
            if (tick) begin
                phase_d[i] = ~phase_q[i];
                // Burst counts each completed pulse on its falling phase.
                if (mode_q[i] == 2'b11 && phase_q[i]) begin
                    cnt_d[i] = cnt_q[i] - 4'd1;
                    if (cnt_q[i] <= 4'd1) begin
                        cnt_d[i]  = 4'd0;
                        mode_d[i] = 2'b00;
                    end
                end
            end

            if (commit && bus.addr == 4'(i)) begin
                mode_d[i] = bus.d_in[1:0];
                cnt_d[i]  = bus.d_in[5:2];
                // Restart the prescaler so the first lit half-period is full length.
                if (bus.d_in[1]) begin
                    phase_d[i] = 1'b1;
                    div_d      = '0;
                end
                if (bus.d_in[1:0] == 2'b11 && bus.d_in[5:2] == 4'd0) begin
                    mode_d[i] = 2'b00;
                end
            end

            if (bus.addr == 4'(i)) begin
                rdata = {2'b00, cnt_q[i], mode_q[i]};
            end

            led_d[i] = (en_q & ((mode_q[i] == 2'b01) | (mode_q[i][1] & phase_q[i]))) ^ inv_q;
        end

        if (commit && bus.addr == ADDR_GLOBAL) begin
            en_d  = bus.d_in[0];
            inv_d = bus.d_in[1];
        end

        if (bus.addr == ADDR_GLOBAL) begin
            rdata = {6'b000000, inv_q, en_q};
        end else if (bus.addr == ADDR_ID) begin
            rdata = 8'(N_LED);
        end

        d_out_d = rd_act ? rdata : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
            led_q   <= '0;
            div_q   <= '0;
            en_q    <= 1'b1;
            inv_q   <= 1'b0;
            wr_q    <= 1'b0;
            d_out_q <= 8'h00;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            div_q   <= div_d;
            en_q    <= en_d;
            inv_q   <= inv_d;
            wr_q    <= wr_act;
            d_out_q <= d_out_d;
        end
    end

    assign led       = led_q;
    assign bus.d_out = d_out_q;
endmodule

// File: doc/ind_led_bank.md
Name: ind_led_bank

Overview:
- Parametrised successor to the two-LED bus indicator: a bank of N_LED indicator outputs behind the same cs/rd/wr/addr peripheral bus.
- Each channel has a programmable mode: off, on, blink, or counted burst. A shared prescaler sets the blink rate.
- Adds readback, a global enable and output polarity control.
- Sits on the CPU peripheral bus next to the other memory-mapped I/O blocks and drives board LEDs directly.

Parameters:
- N_LED, 2, number of channels, legal 1..8.
- BLINK_DIV, 25000000, clocks per blink half-period, minimum 2. Benches use 4.
- DIV_W, 25, prescaler counter width; must hold BLINK_DIV-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cs  in  1  chip select
- rd  in  1  read strobe, qualified by cs
- wr  in  1  write strobe, qualified by cs
- addr  in  4  register address
- d_in  in  8  write data
- d_out  out  8  registered read data
- led  out  N_LED  LED drive, bit i = channel i

Behaviour:
- Reset (rst=0, async):
  - All channel registers clear to mode 00 and count 0.
  - Global register resets to 0x01 (enable=1, invert=0).
  - Prescaler, phase flops and the write-edge flop clear; led=0, d_out=0x00.
- Write commit:
  - A write is committed on the first rising edge where cs&wr=1 and the previous cycle had cs&wr=0. One write per strobe assertion; holding cs/wr high does not re-write.
  - If rd and wr are both asserted, the write wins and no read occurs.
- Register map:
  - 0x0..N_LED-1: channel ctrl. d_in[1:0] mode (00 off, 01 on, 10 blink, 11 burst); d_in[5:2] burst count.
  - 0x8: global. bit0 enable, bit1 invert.
  - 0xF: read-only ID, returns N_LED.
  - Other addresses, including channel index ≥ N_LED: writes ignored, reads return 0x00.
- Read:
  - On a cs&rd edge where wr=0, d_out loads the addressed value; 1-cycle latency.
  - Channel readback is {2'b00, remaining count, mode}.
  - d_out returns to 0x00 the cycle after rd or cs deasserts.
- Prescaler:
  - Counts 0..BLINK_DIV-1 while enable=1, then wraps. tick=1 on the wrap cycle.
  - Counter and tick are frozen while enable=0.
- Per-channel phase flop:
  - A committed write of mode 10 or 11 sets phase=1 and resets the prescaler to 0, so the on-time is a full half-period.
  - phase toggles on each tick.
- Burst:
  - On every phase 1→0 transition the count decrements.
  - When the count reaches 0, mode becomes 00 on that same edge.
  - A burst write with count 0 goes directly to mode 00.
  - Rewriting a channel mid-burst restarts it with the new count.
- LED output (registered, updates 1 cycle after the state change):
  - raw = 0 for off, 1 for on, phase for blink/burst.
  - led[i] = (enable ? raw : 0) XOR invert.
- Reset mid-burst aborts immediately to reset values.

Test Plan:
- Reset then idle, BLINK_DIV=4 -> led=00 and d_out=0x00 throughout. Read 0xF -> d_out=0x02 one cycle after the strobe.
- Write 0x0=0x01, then hold cs/wr high 10 cycles with d_in=0x00 -> led[0]=1 one cycle after commit and stays 1 (single commit). Read 0x0 -> 0x01.
- Write 0x1=0x02 (blink) -> led[1] high 4 clocks, low 4 clocks, repeating. Write 0x8=0x00 -> led=00 and frozen. Write 0x8=0x01 -> blinking resumes from the frozen phase.
- Write 0x0=0x0F (burst, count 3) -> exactly 3 high pulses of 4 clocks separated by 4 low clocks, then led[0]=0. Read 0x0 -> 0x00.
- Write 0x8=0x03 (invert) with both channels off -> led=11. Write to 0x5 and 0x9 -> no change to led; reads of 0x5 and 0x9 return 0x00.
- Start burst count 5 and assert rst after 2 pulses -> led=00 and d_out=0x00 immediately. After release, read 0x0=0x00 and 0x8=0x01.
